// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sequencing a shared MUX4: drives SD2/SD1, inserts a
// one-cycle select-settle slot before each grant and caps tenure at HOLD_MAX.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       CK,
    input  logic       CD,
    input  logic [3:0] REQ,
    input  logic [3:0] DONE,
    output logic [3:0] GNT,
    output logic       SD1,
    output logic       SD2,
    output logic       BUSY
);
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OWN   = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]   sel_q;
    logic               busy_q;

    logic [IDX_W-1:0]   base_c;
    logic [IDX_W-1:0]   cand_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_found_c;
    logic               release_c;

    // Winner search starts after the base; base itself is checked last.
    always_comb begin
        base_c      = (state_q == OWN) ? owner_q : ptr_q;
        win_found_c = 1'b0;
        win_idx_c   = base_c;
        cand_c      = base_c;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_c = base_c + IDX_W'(k);
            if (REQ[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
        release_c = !REQ[owner_q] || DONE[owner_q] || (cnt_q == CNT_W'(HOLD_MAX));
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_c) begin
                        owner_q <= win_idx_c;
                        sel_q   <= win_idx_c;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (REQ[owner_q]) begin
                        gnt_q   <= N_REQ'(1) << owner_q;
                        cnt_q   <= CNT_W'(1);
                        state_q <= OWN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                OWN: begin
                    if (release_c) begin
                        gnt_q <= '0;
                        ptr_q <= owner_q;
                        if (win_found_c) begin
                            owner_q <= win_idx_c;
                            sel_q   <= win_idx_c;
                            state_q <= SETUP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign GNT  = gnt_q;
    assign SD1  = sel_q[0];
    assign SD2  = sel_q[1];
    assign BUSY = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: two arbiters (HOLD_MAX 4 and 1) share stimulus and are
// compared each cycle against a tenure-level model, plus directed scenarios.
module tb_mux4_rr_arbiter;
    logic       ck;
    logic       cd;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt_a, gnt_b;
    logic       sd1_a, sd2_a, busy_a;
    logic       sd1_b, sd2_b, busy_b;

    int n_pass  = 0;
    int n_total = 0;

    mux4_rr_arbiter #(.HOLD_MAX(4)) u_dut_a (
        .CK(ck), .CD(cd), .REQ(req), .DONE(done),
        .GNT(gnt_a), .SD1(sd1_a), .SD2(sd2_a), .BUSY(busy_a)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1)) u_dut_b (
        .CK(ck), .CD(cd), .REQ(req), .DONE(done),
        .GNT(gnt_b), .SD1(sd1_b), .SD2(sd2_b), .BUSY(busy_b)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: owner (-1 none), pending select (-1 none), tenure length, last winner.
    int m_own[2], m_pend[2], m_ptr[2], m_ten[2], m_sel[2];
    int hmax[2] = '{4, 1};

    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int u);
        int pick;
        if (cd) begin
            m_own[u] = -1; m_pend[u] = -1; m_ptr[u] = 3; m_ten[u] = 0; m_sel[u] = 0;
        end else if (m_own[u] >= 0) begin
            if (!req[m_own[u]] || done[m_own[u]] || m_ten[u] == hmax[u]) begin
                m_ptr[u] = m_own[u];
                m_own[u] = -1;
                pick = search(req, m_ptr[u]);
                if (pick >= 0) begin m_pend[u] = pick; m_sel[u] = pick; end
            end else begin
                m_ten[u]++;
            end
        end else if (m_pend[u] >= 0) begin
            if (req[m_pend[u]]) begin m_own[u] = m_pend[u]; m_ten[u] = 1; end
            m_pend[u] = -1;
        end else begin
            pick = search(req, m_ptr[u]);
            if (pick >= 0) begin m_pend[u] = pick; m_sel[u] = pick; end
        end
    endtask

    function automatic logic [3:0] m_gnt(input int u);
        return (m_own[u] >= 0) ? (4'b0001 << m_own[u]) : 4'b0000;
    endfunction

    // Apply inputs for one edge, advance the model, then compare after the edge.
    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic c);
        req = r; done = d; cd = c;
        model_step(0);
        model_step(1);
        @(posedge ck);
        #1;
        check("gnt_a",  8'(gnt_a), 8'(m_gnt(0)));
        check("sel_a",  8'({sd2_a, sd1_a}), 8'(m_sel[0]));
        check("busy_a", 8'(busy_a), 8'((m_own[0] >= 0) || (m_pend[0] >= 0)));
        check("gnt_b",  8'(gnt_b), 8'(m_gnt(1)));
        check("sel_b",  8'({sd2_b, sd1_b}), 8'(m_sel[1]));
        check("busy_b", 8'(busy_b), 8'((m_own[1] >= 0) || (m_pend[1] >= 0)));
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);
    endtask

    initial begin
        req = '0; done = '0; cd = 1'b1;
        #1;

        // Reset then single request to requester 2.
        do_reset();
        check("rst_gnt", 8'(gnt_a), 8'h00);
        check("rst_sel", 8'({sd2_a, sd1_a}), 8'h00);
        check("rst_busy", 8'(busy_a), 8'h00);
        drive(4'b0100, 4'b0000, 1'b0);
        check("e0_sel", 8'({sd2_a, sd1_a}), 8'h02);
        check("e0_gnt", 8'(gnt_a), 8'h00);
        drive(4'b0100, 4'b0000, 1'b0);
        check("e1_gnt", 8'(gnt_a), 8'h04);
        for (int i = 0; i < 3; i++) drive(4'b0100, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        check("drop_gnt", 8'(gnt_a), 8'h00);
        check("drop_busy", 8'(busy_a), 8'h00);

        // Round robin with all requesting: 4-cycle grants, 1-cycle gaps.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            check("rr_gnt", 8'(gnt_a), (k % 5 == 0) ? 8'h00 : 8'(4'b0001 << ((k / 5) % 4)));
        end

        // DONE handling: non-owner DONE ignored, owner DONE releases.
        do_reset();
        drive(4'b0010, 4'b0000, 1'b0);
        drive(4'b0010, 4'b0000, 1'b0);
        check("own1_gnt", 8'(gnt_a), 8'h02);
        drive(4'b0011, 4'b0100, 1'b0);
        check("nonown_done", 8'(gnt_a), 8'h02);
        drive(4'b0011, 4'b0010, 1'b0);
        check("done_rel", 8'(gnt_a), 8'h00);
        check("done_sel", 8'({sd2_a, sd1_a}), 8'h00);
        drive(4'b0011, 4'b0000, 1'b0);
        check("done_next", 8'(gnt_a), 8'h01);

        // SETUP abort leaves the pointer untouched.
        do_reset();
        drive(4'b1000, 4'b0000, 1'b0);
        check("abort_sel", 8'({sd2_a, sd1_a}), 8'h03);
        check("abort_busy", 8'(busy_a), 8'h01);
        drive(4'b0000, 4'b0000, 1'b0);
        check("abort_gnt", 8'(gnt_a), 8'h00);
        check("abort_idle", 8'(busy_a), 8'h00);
        drive(4'b1001, 4'b0000, 1'b0);
        drive(4'b1001, 4'b0000, 1'b0);
        check("abort_ptr", 8'(gnt_a), 8'h01);

        // Reset mid-grant.
        do_reset();
        for (int i = 0; i < 4; i++) drive(4'b0100, 4'b0000, 1'b0);
        check("mid_gnt", 8'(gnt_a), 8'h04);
        drive(4'b0110, 4'b0000, 1'b1);
        check("mid_rst_gnt", 8'(gnt_a), 8'h00);
        check("mid_rst_sel", 8'({sd2_a, sd1_a}), 8'h00);
        check("mid_rst_busy", 8'(busy_a), 8'h00);
        drive(4'b0110, 4'b0000, 1'b0);
        drive(4'b0110, 4'b0000, 1'b0);
        check("mid_regrant", 8'(gnt_a), 8'h02);

        // HOLD_MAX = 1: single-cycle pulses every other cycle, select fixed.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(4'b0001, 4'b0000, 1'b0);
            check("h1_gnt", 8'(gnt_b), (k % 2 == 1) ? 8'h01 : 8'h00);
            check("h1_sel", 8'({sd2_b, sd1_b}), 8'h00);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(4'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
                  ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select sequencer for one shared 4:1 MUX4 datapath. Up to four requesters compete for the mux. The block grants one at a time and drives the mux select lines SD1/SD2 so the granted requester's D input reaches Z. It inserts a one-cycle select-settle slot before every grant and bounds each tenure with a hold limit.

## Interface
- HOLD_MAX, 16: maximum consecutive cycles a single grant may stay asserted; legal range 1..255.

- CK  input  1  rising-edge clock
- CD  input  1  reset; synchronous, active-high
- REQ  input  4  request per requester; bit i drives MUX4 input Di
- DONE  input  4  end-of-transfer pulse per requester; only the owner's bit is honoured
- GNT  output  4  one-hot grant (all zero when idle or settling); registered
- SD1  output  1  mux select bit 0 (index[0]); registered
- SD2  output  1  mux select bit 1 (index[1]); registered
- BUSY  output  1  high in SETUP or OWN; registered

## Operation
- Select encoding follows MUX4: index 0 = SD2,SD1 = 00 (D0); 1 = 01 (D1); 2 = 10 (D2); 3 = 11 (D3).
- State: 2-bit FSM with states IDLE, SETUP and OWN; 2-bit owner index; 2-bit last-winner pointer PTR; 8-bit hold counter CNT.
- Winner search: the first set REQ bit scanning PTR+1, PTR+2, PTR+3, PTR (all mod 4). The previous owner therefore has the lowest priority.
- IDLE:
  - REQ = 0: stay in IDLE; SD1/SD2 hold their last value.
  - Otherwise: latch the winner index, load SD2/SD1 with it, go to SETUP.
- SETUP (exactly one cycle, GNT = 0):
  - REQ[owner] still high: assert GNT[owner], set CNT = 1, go to OWN.
  - REQ[owner] dropped: abort to IDLE with PTR unchanged; no grant is issued.
- OWN: GNT[owner] high, CNT increments each cycle. Release at the edge where any of these holds:
  - REQ[owner] = 0
  - DONE[owner] = 1
  - CNT == HOLD_MAX
- On release:
  - GNT goes to 0 and PTR takes the owner value.
  - The winner search runs the same edge using current REQ, with the releasing owner at lowest priority. If the releasing owner still requests, it is eligible.
  - Any winner: load SD1/SD2 and go to SETUP. No winner: go to IDLE.
- DONE bits of non-owners are ignored at all times. REQ changes on non-owners never disturb a current grant.
- Reset (CD = 1 at an edge, from any state including mid-grant):
  - GNT = 0000, SD1 = 0, SD2 = 0, BUSY = 0, CNT = 0.
  - PTR = 3, so the first search starts at requester 0. State = IDLE.
- BUSY = 1 exactly when the state is SETUP or OWN.

## Timing
- Request to grant: REQ sampled high in IDLE at edge e. SD1/SD2 are valid after e; GNT is high after e+1. Latency is 2 cycles.
- The select is always stable for at least one full cycle before and throughout GNT. SD1/SD2 change only at an edge where GNT becomes or stays 0.
- Handoff gap: release at edge e gives GNT = 0 after e, with the new select valid after e. The next GNT is high after e+1, a 1-cycle bubble.
- Maximum tenure: GNT is high for at most HOLD_MAX consecutive cycles. With HOLD_MAX = 1, each grant lasts 1 cycle, then a 1-cycle gap.
- Release takes effect at the sampling edge; GNT falls in the same cycle the DONE or REQ drop is observed plus one.
- Worst-case wait for a continuously requesting input is 3 × (HOLD_MAX + 1) + 2 cycles.
- CD dominates all other inputs at the same edge.

## Test plan
- Reset then single request: assert CD for 2 cycles, then REQ = 0100 at edge 0.
  - Expect SD2,SD1 = 10 after edge 0 and GNT = 0100 after edge 1.
  - Drop REQ at edge 5: expect GNT = 0000 after edge 5 and BUSY = 0.
- Round robin: REQ = 1111 held, HOLD_MAX = 4, DONE = 0.
  - Expect grants in order 0001, 0010, 0100, 1000, 0001, …
  - Each grant lasts 4 cycles, with a 1-cycle GNT = 0 gap between grants.
- DONE handling, owner 1 (GNT = 0010):
  - DONE = 0100 (non-owner): no effect.
  - DONE = 0010 next cycle: GNT falls the following edge. With REQ = 0011, requester 0 is granted 2 cycles after DONE.
- SETUP abort: REQ = 1000 for one cycle only.
  - Expect SD2,SD1 = 11 and BUSY = 1 for one cycle, GNT never set, return to IDLE.
  - A subsequent REQ = 1001 grants requester 0 first (PTR unchanged at 3).
- Reset mid-grant: during GNT = 0100 with CNT = 3, assert CD for one edge.
  - Expect GNT = 0000, SD1 = SD2 = 0, BUSY = 0 after that edge.
  - With REQ = 0110 held, requester 1 is granted 2 cycles after CD drops.
- Hold limit at the boundary: HOLD_MAX = 1 and REQ = 0001 held.
  - Expect a GNT = 0001 1-cycle pulse every 2 cycles, with SD1/SD2 constant at 00.
